stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter LEN, default 8: data width per beat.
REQ-002 SHALL have parameter N, default 4: number of source ports, 2..8.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port s_valid, input, N: per-source beat valid.
REQ-006 SHALL have port s_last, input, N: per-source last beat of packet.
REQ-007 SHALL have port s_data, input, N*LEN: source i on bits [i*LEN +: LEN].
REQ-008 SHALL have port s_ready, output, N: per-source beat accepted when s_valid[i] && s_ready[i].
REQ-009 SHALL have port m_ready, input, 1: sink accepts beat.
REQ-010 SHALL have port m_valid, output, 1: registered output beat valid.
REQ-011 SHALL have port m_last, output, 1: registered last flag of output beat.
REQ-012 SHALL have port m_data, output, LEN: registered output data.
REQ-013 SHALL have port m_src, output, $clog2(N) (min 1): index of the source that produced the current m_data.
REQ-014 SHALL have port timeout, output, 1: one-cycle pulse on watchdog release (tied 0 when the feature is compiled out).

Function
REQ-015 SHALL implement FSM states IDLE and BUSY, plus a grant index g and a round-robin pointer ptr.
REQ-016 IDLE: if any s_valid is set, the FSM SHALL pick the first set index scanning ptr, ptr+1, ... mod N, load g, and enter BUSY next cycle; no beat is accepted in IDLE.
REQ-017 BUSY: s_ready[g] SHALL equal (!m_valid || m_ready); every other s_ready bit SHALL be 0.
REQ-018 On an accepted beat, m_data/m_last/m_src SHALL load s_data[g]/s_last[g]/g and m_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-019 When m_valid && m_ready and no new beat is accepted, m_valid SHALL clear next cycle; m_data SHALL hold while m_valid && !m_ready.
REQ-020 An accepted beat with s_last[g]=1 SHALL return the FSM to IDLE and set ptr=(g+1) mod N; the grant SHALL NOT change mid-packet.
REQ-021 A single-beat packet (s_last=1 on the first beat) SHALL be legal.
REQ-022 Zero-wait throughput SHALL be 1 beat/cycle within a packet; the packet boundary costs exactly 1 IDLE cycle.
REQ-023 s_valid dropping mid-packet SHALL keep the grant; other sources SHALL stay stalled.
REQ-024 ptr wrap from N-1 SHALL go to 0.

Reset
REQ-025 rst SHALL force, asynchronously: state=IDLE, g=0, ptr=0, m_valid=0, m_last=0, m_data=0, m_src=0, timeout=0, watchdog count=0.
REQ-026 Reset asserted mid-packet SHALL discard the packet; after release, arbitration SHALL restart from source 0.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: in BUSY, a 4-bit counter SHALL increment each cycle with s_valid[g]=0 and clear on any accepted beat; on reaching 15 the block SHALL pulse timeout, go to IDLE, and set ptr=(g+1) mod N, leaving the output register untouched.
REQ-028 Macro ARB_TIMEOUT_EN undefined: no counter SHALL exist, timeout SHALL be constant 0, and the grant SHALL be held indefinitely.

Verification
REQ-029 Reset then s_valid=4'b0100 with a 3-beat packet AA,BB,CC (last on CC), m_ready=1 -> m_src=2; AA on m_valid 2 cycles after s_valid; BB, CC back-to-back with m_last on CC.
REQ-030 All four sources valid continuously with 1-beat packets, m_ready=1 -> grant order 0,1,2,3,0, one beat every 2 cycles.
REQ-031 Source 1 mid-packet with m_ready=0 for 3 cycles -> m_data holds, s_ready[1]=0, no beat lost or duplicated.
REQ-032 Source 3 granted, then its last beat accepted while source 0 is valid -> next grant is 0 (ptr wrap).
REQ-033 rst pulsed during beat 2 of a 4-beat packet -> all outputs 0 immediately; the next grant follows the ptr=0 rule.
REQ-034 With ARB_TIMEOUT_EN defined, source 0 stalls after its first beat -> timeout pulses exactly 15 cycles later and source 1 is granted next; with the macro undefined, source 0 stays granted.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter merging N valid/ready beat streams into one registered output.
// Optional ARB_TIMEOUT_EN adds a watchdog that releases a grant whose owner stalls mid-packet.
module stream_rr_arbiter #(
  parameter int unsigned LEN = 8,
  parameter int unsigned N   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N-1:0]                           s_valid,
  input  logic [N-1:0]                           s_last,
  input  logic [N*LEN-1:0]                       s_data,
  output logic [N-1:0]                           s_ready,
  input  logic                                   m_ready,
  output logic                                   m_valid,
  output logic                                   m_last,
  output logic [LEN-1:0]                         m_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   m_src,
  output logic                                   timeout
);

  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [GW-1:0]  g_q, g_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic [LEN-1:0] m_data_q, m_data_d;
  logic [GW-1:0]  m_src_q, m_src_d;
`ifdef ARB_TIMEOUT_EN
  logic           timeout_q, timeout_d;
  logic [3:0]     wd_q, wd_d;
`endif

  logic           sel_valid, sel_last, room, take, found;
  logic [LEN-1:0] sel_data;
  logic [GW-1:0]  pick, g_inc;

  // Granted source's beat, ready fan-out and the handshake that fires this cycle
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    s_ready   = '0;
    room      = !m_valid_q || m_ready;
    for (int i = 0; i < int'(N); i++) begin
      if (g_q == GW'(i)) begin
        sel_valid  = s_valid[i];
        sel_last   = s_last[i];
        sel_data   = s_data[i*LEN +: LEN];
        s_ready[i] = (state_q == ST_BUSY) && room;
      end
    end
    take  = (state_q == ST_BUSY) && sel_valid && room;
    g_inc = (g_q == GW'(N - 1)) ? '0 : g_q + GW'(1);
  end

  // Round-robin scan: indices at or above ptr first, then wrap to the bottom
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && s_valid[i] && (GW'(i) >= ptr_q)) begin
        found = 1'b1;
        pick  = GW'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && s_valid[i]) begin
        found = 1'b1;
        pick  = GW'(i);
      end
    end
  end

  // Next-state and output-register logic
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;
`ifdef ARB_TIMEOUT_EN
    timeout_d = 1'b0;
    wd_d      = wd_q;
`endif
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          g_d     = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (take) begin
          m_valid_d = 1'b1;
          m_last_d  = sel_last;
          m_data_d  = sel_data;
          m_src_d   = g_q;
`ifdef ARB_TIMEOUT_EN
          wd_d      = '0;
`endif
          if (sel_last) begin
            state_d = ST_IDLE;
            ptr_d   = g_inc;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (!sel_valid) begin
          // Fifteenth consecutive starved cycle releases the grant
          if (wd_q == 4'd14) begin
            wd_d      = '0;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            ptr_d     = g_inc;
          end else begin
            wd_d = wd_q + 4'd1;
          end
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      g_q       <= '0;
      ptr_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
`ifdef ARB_TIMEOUT_EN
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench for stream_rr_arbiter: a packet-level arbitration model predicts
// handshakes and output beats; a separate monitor checks every presented output beat in order.
module tb_stream_rr_arbiter;

  localparam int N   = 4;
  localparam int LEN = 8;

  logic             clk;
  logic             rst;
  logic [N-1:0]     s_valid, s_last, s_ready;
  logic [N*LEN-1:0] s_data;
  logic             m_ready, m_valid, m_last, timeout;
  logic [LEN-1:0]   m_data;
  logic [1:0]       m_src;

  stream_rr_arbiter #(.LEN(LEN), .N(N)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
    .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last), .m_data(m_data),
    .m_src(m_src), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [LEN-1:0] d; logic l; } beat_t;
  typedef struct { logic [LEN-1:0] d; logic l; int src; } exp_t;

  beat_t srcq[N][$];
  exp_t  expq[$];
  int    checks = 0;
  int    errors = 0;

  // Arbitration model: current packet owner (-1 = none), next priority, output occupancy
  int owner = -1;
  int prio  = 0;
  int stall = 0;
  bit out_valid = 0;
  bit exp_to = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    owner = -1; prio = 0; stall = 0; out_valid = 0; exp_to = 0;
    expq.delete();
  endtask

  task automatic add_pkt(input int src, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.d = LEN'(base + k);
      b.l = (k == len - 1);
      srcq[src].push_back(b);
    end
  endtask

  task automatic drive(input int vpct, input int rpct);
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && int'($urandom_range(99)) < vpct) begin
        s_valid[i] = 1'b1;
        s_data[i*LEN +: LEN] = srcq[i][0].d;
        s_last[i] = srcq[i][0].l;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*LEN +: LEN] = LEN'($urandom);
        s_last[i] = 1'($urandom);
      end
    end
    m_ready = (int'($urandom_range(99)) < rpct);
  endtask

  // One cycle of the reference model, evaluated with inputs stable mid-cycle
  task automatic model_step();
    logic [N-1:0] er;
    bit ov, found;
    er = '0;
    ov = 0;
    if (owner >= 0) begin
      if (!out_valid || m_ready) er[owner] = 1'b1;
      ov = s_valid[owner];
    end
    chk("s_ready", 32'(s_ready), 32'(er));
    chk("m_valid", 32'(m_valid), 32'(out_valid));
    chk("timeout", 32'(timeout), 32'(exp_to));
    exp_to = 0;
    if (owner < 0) begin
      if (out_valid && m_ready) out_valid = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (prio + k) % N;
        if (!found && s_valid[idx]) begin
          found = 1;
          owner = idx;
        end
      end
    end else if (ov && er[owner]) begin
      exp_t e;
      e.d = srcq[owner][0].d;
      e.l = srcq[owner][0].l;
      e.src = owner;
      expq.push_back(e);
      void'(srcq[owner].pop_front());
      out_valid = 1;
      stall = 0;
      if (e.l) begin
        prio = (owner + 1) % N;
        owner = -1;
      end
    end else begin
      if (out_valid && m_ready) out_valid = 0;
`ifdef ARB_TIMEOUT_EN
      if (!ov) begin
        stall++;
        if (stall == 15) begin
          exp_to = 1;
          prio = (owner + 1) % N;
          owner = -1;
          stall = 0;
        end
      end
`endif
    end
  endtask

  task automatic step(input int vpct, input int rpct);
    drive(vpct, rpct);
    @(negedge clk);
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_cycles(input int n, input int vpct, input int rpct);
    repeat (n) step(vpct, rpct);
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (expq.size() == 0) && !out_valid && (owner < 0);
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) idle = 0;
    return idle;
  endfunction

  task automatic run_drain(input int vpct, input int rpct, input int budget);
    int c;
    c = 0;
    while (!all_idle() && c < budget) begin
      step(vpct, rpct);
      c++;
    end
    chk("drain_budget", 32'(all_idle()), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"},  32'(m_last),  32'd0);
    chk({tag, "_m_data"},  32'(m_data),  32'd0);
    chk({tag, "_m_src"},   32'(m_src),   32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
  endtask

  task automatic full_reset();
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
    model_clear();
    for (int i = 0; i < N; i++) srcq[i].delete();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset mid-cycle; queued source beats survive and are re-offered afterwards
  task automatic pulse_reset();
    rst = 1'b1; s_valid = '0;
    #1;
    check_zero_outputs("async_rst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
  endtask

  // Monitor: every presented beat must match the oldest predicted beat; pop on handshake
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none at %0t", m_data, $time);
      end else begin
        chk("m_data", 32'(m_data), 32'(expq[0].d));
        chk("m_last", 32'(m_last), 32'(expq[0].l));
        chk("m_src",  32'(m_src),  32'(expq[0].src));
        if (m_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    full_reset();

    // Single source, 3-beat packet
    add_pkt(2, 3, 8'hAA);
    srcq[2][1].d = 8'hBB;
    srcq[2][2].d = 8'hCC;
    run_drain(100, 100, 40);

    // All sources saturated with single-beat packets
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_pkt(i, 1, 16 * i + r);
    run_drain(100, 100, 60);

    // Sink backpressure mid-packet
    add_pkt(1, 5, 8'h40);
    run_cycles(3, 100, 100);
    run_cycles(3, 100, 0);
    run_drain(100, 100, 40);

    // Pointer wrap: leave ptr at 3, then source 3 and source 0 compete
    add_pkt(2, 1, 8'h70);
    run_drain(100, 100, 20);
    add_pkt(3, 2, 8'h80);
    add_pkt(0, 1, 8'h90);
    run_drain(100, 100, 30);

    // Reset during beat 2 of a 4-beat packet
    add_pkt(1, 4, 8'hA0);
    run_cycles(3, 100, 100);
    pulse_reset();
    add_pkt(3, 1, 8'hB0);
    run_drain(100, 100, 40);

    // Owner starves after its first beat while another source waits
    add_pkt(0, 1, 8'hC0);
    srcq[0][0].l = 1'b0;
    add_pkt(1, 1, 8'hD0);
    run_cycles(30, 100, 100);
    full_reset();

    // Randomized traffic with random valid gaps and backpressure
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < N; i++) begin
        int np;
        np = int'($urandom_range(3));
        for (int p = 0; p < np; p++) add_pkt(i, 1 + int'($urandom_range(3)), int'($urandom_range(255)));
      end
      run_drain(70, 60, 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
